// File: rtl/img_pkg.sv
// Shared image geometry, FSM encodings and ring-index helper for the line-buffer window path.
package img_pkg;

  localparam int IMG_WIDTH = 512;
  localparam int PIX_W     = 8;
  localparam int NUM_LB    = 4;
  localparam int WIN_W     = 9 * PIX_W;
  localparam int CNT_W     = $clog2(IMG_WIDTH);
  localparam int SEL_W     = $clog2(NUM_LB);
  localparam int FILL_W    = $clog2(NUM_LB * IMG_WIDTH) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  // Buffer index `off` lines after `sel`; the two-bit width gives the mod-4 wrap.
  function automatic logic [SEL_W-1:0] lbIndex(logic [SEL_W-1:0] sel, int off);
    return sel + SEL_W'(off);
  endfunction

endpackage

// File: rtl/lineBuffer.sv
// One line of pixel storage with a three-pixel tap starting at the read pointer.
// Pointers use a synchronous active-low reset; memory contents are never cleared.
module lineBuffer
  import img_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     data_i,
  input  logic                 data_valid,
  input  logic                 read_data,
  output logic [3*PIX_W-1:0]   data_o
);

  logic [PIX_W-1:0] mem [IMG_WIDTH];
  logic [CNT_W-1:0] wrPtr_q;
  logic [CNT_W-1:0] rdPtr_q;

  always_ff @(posedge clk) begin
    if (data_valid) begin
      mem[wrPtr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (data_valid) wrPtr_q <= wrPtr_q + 1'b1;
      if (read_data)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Tap indices wrap within the line, so the last two taps fold back to columns 0 and 1.
  assign data_o = {mem[rdPtr_q], mem[rdPtr_q + CNT_W'(1)], mem[rdPtr_q + CNT_W'(2)]};

endmodule

// File: rtl/line_buffer_ctrl.sv
// Rotates four line buffers (three read, one written) into a registered 3x3 window stream.
module line_buffer_ctrl
  import img_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_in_valid,
  input  logic               win_ready,
  output logic [WIN_W-1:0]   pix_win,
  output logic               pix_win_valid,
  output logic               line_done_irq,
  output logic               ovf_err
);

  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(NUM_LB * IMG_WIDTH);
  localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * IMG_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_COL   = CNT_W'(IMG_WIDTH - 1);

  logic [CNT_W-1:0]  wrCnt_q, wrCnt_d, rdCnt_q, rdCnt_d;
  logic [SEL_W-1:0]  wrSel_q, wrSel_d, rdSel_q, rdSel_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [0:0]        state_q, state_d;
  logic [WIN_W-1:0]  pixWin_q;
  logic              pixWinValid_q, lineDone_q, ovf_q;

  logic              wrAccept, rdEn, rdLast;
  logic [3*PIX_W-1:0] lbOut [NUM_LB];
  logic [WIN_W-1:0]  window;

  assign wrAccept = pix_in_valid && (fill_q < FILL_FULL);
  assign rdEn     = (state_q == READ) && win_ready;
  assign rdLast   = rdEn && (rdCnt_q == LAST_COL);

  // Buffer i is read when it is one of the three rows starting at rdSel (i - rdSel != 3 mod 4).
  for (genvar i = 0; i < NUM_LB; i++) begin : gLb
    logic [SEL_W-1:0] relIdx;
    assign relIdx = SEL_W'(i) - rdSel_q;
    lineBuffer uLb (
      .clk        (clk),
      .rst        (~rst),
      .data_i     (pix_in),
      .data_valid (wrAccept && (wrSel_q == SEL_W'(i))),
      .read_data  (rdEn && (relIdx != SEL_W'(3))),
      .data_o     (lbOut[i])
    );
  end

  assign window = {lbOut[lbIndex(rdSel_q, 0)], lbOut[lbIndex(rdSel_q, 1)], lbOut[lbIndex(rdSel_q, 2)]};

  always_comb begin
    wrCnt_d = wrCnt_q;
    wrSel_d = wrSel_q;
    rdCnt_d = rdCnt_q;
    rdSel_d = rdSel_q;
    fill_d  = fill_q;
    state_d = state_q;

    if (wrAccept) begin
      if (wrCnt_q == LAST_COL) begin
        wrCnt_d = '0;
        wrSel_d = lbIndex(wrSel_q, 1);
      end else begin
        wrCnt_d = wrCnt_q + 1'b1;
      end
    end

    case ({wrAccept, rdEn})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    if (rdEn) begin
      if (rdLast) begin
        rdCnt_d = '0;
        rdSel_d = lbIndex(rdSel_q, 1);
      end else begin
        rdCnt_d = rdCnt_q + 1'b1;
      end
    end

    // Leaving READ after every line forces one idle cycle before the next line's read.
    case (state_q)
      IDLE:    if (fill_q >= FILL_START) state_d = READ;
      READ:    if (rdLast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrCnt_q       <= '0;
      wrSel_q       <= '0;
      rdCnt_q       <= '0;
      rdSel_q       <= '0;
      fill_q        <= '0;
      state_q       <= IDLE;
      pixWin_q      <= '0;
      pixWinValid_q <= 1'b0;
      lineDone_q    <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      wrCnt_q       <= wrCnt_d;
      wrSel_q       <= wrSel_d;
      rdCnt_q       <= rdCnt_d;
      rdSel_q       <= rdSel_d;
      fill_q        <= fill_d;
      state_q       <= state_d;
      pixWinValid_q <= rdEn;
      lineDone_q    <= rdLast;
      if (rdEn) pixWin_q <= window;
      if (pix_in_valid && !wrAccept) ovf_q <= 1'b1;
    end
  end

  assign pix_win       = pixWin_q;
  assign pix_win_valid = pixWinValid_q;
  assign line_done_irq = lineDone_q;
  assign ovf_err       = ovf_q;

endmodule
